// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer: latches rising-edge requests as pending, arms the lowest
// enabled index and issues a one-cycle strobe to fetch when it is neither stalled nor flushed.
module irq_sequencer #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               rti,
    input  logic               rsi,
    output logic               interrupt,
    output logic               in_service,
    output logic [ID_W-1:0]    cause_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] en_mask,
    output logic               spurious_ret,
    output logic [CNT_W-1:0]   irq_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               ret;

    assign rise = irq_src & ~src_q;
    assign cand = pending & en_mask;
    assign ret  = rti | rsi;

    // Strobe only when fetch can act on it this very cycle.
    assign interrupt = (state == ARM) && !stall && !flush;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Pending bit of the strobed source is cleared; a same-cycle rise overrides below.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = interrupt && (cause_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            src_q        <= '0;
            pending      <= '0;
            en_mask      <= '0;
            cause_id     <= '0;
            irq_count    <= '0;
            spurious_ret <= 1'b0;
            in_service   <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~clr) | rise;

            if (en_we) begin
                en_mask <= en_wdata;
            end

            if (ret && (state != SERVICE)) begin
                spurious_ret <= 1'b1;
            end

            if (interrupt && (irq_count != '1)) begin
                irq_count <= irq_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    in_service <= 1'b0;
                    if (|cand) begin
                        state    <= ARM;
                        cause_id <= winner;
                    end
                end
                ARM: begin
                    // Committed once armed: mask changes here do not cancel.
                    if (interrupt) begin
                        state      <= SERVICE;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (ret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: inputs change 1ns after each rising edge, outputs are
// checked 1ns later so the combinational strobe reflects the current stall/flush.
module tb_irq_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_src;
    logic        en_we;
    logic [3:0]  en_wdata;
    logic        stall;
    logic        flush;
    logic        rti;
    logic        rsi;
    logic        interrupt;
    logic        in_service;
    logic [1:0]  cause_id;
    logic [3:0]  pending;
    logic [3:0]  en_mask;
    logic        spurious_ret;
    logic [15:0] irq_count;

    int total = 0;
    int bad   = 0;

    irq_sequencer #(.NUM_SRC(4), .ID_W(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .en_we        (en_we),
        .en_wdata     (en_wdata),
        .stall        (stall),
        .flush        (flush),
        .rti          (rti),
        .rsi          (rsi),
        .interrupt    (interrupt),
        .in_service   (in_service),
        .cause_id     (cause_id),
        .pending      (pending),
        .en_mask      (en_mask),
        .spurious_ret (spurious_ret),
        .irq_count    (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_interrupt"}, 32'(interrupt), 32'd0);
        chk({tag, "_in_service"}, 32'(in_service), 32'd0);
        chk({tag, "_cause_id"}, 32'(cause_id), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_en_mask"}, 32'(en_mask), 32'd0);
        chk({tag, "_spurious"}, 32'(spurious_ret), 32'd0);
        chk({tag, "_count"}, 32'(irq_count), 32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        irq_src = '0;
        en_we   = 1'b0;
        en_wdata = '0;
        stall   = 1'b0;
        flush   = 1'b0;
        rti     = 1'b0;
        rsi     = 1'b0;
        cycle();
        rst_n   = 1'b1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        en_we    = 1'b1;
        en_wdata = m;
        cycle();
        en_we    = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset values
        do_reset();
        #1;
        chk_reset("rst");

        // 1: single source, minimum latency
        set_mask(4'b1111);
        #1;
        chk("t1_mask", 32'(en_mask), 32'hf);
        irq_src = 4'b0100;                       // cycle T
        #1;
        chk("t1_T_int", 32'(interrupt), 32'd0);
        cycle(); irq_src = '0; #1;               // T+1
        chk("t1_T1_pend", 32'(pending), 32'b0100);
        chk("t1_T1_int", 32'(interrupt), 32'd0);
        cycle(); #1;                             // T+2
        chk("t1_T2_int", 32'(interrupt), 32'd1);
        chk("t1_T2_cause", 32'(cause_id), 32'd2);
        chk("t1_T2_insvc", 32'(in_service), 32'd0);
        cycle(); #1;                             // T+3
        chk("t1_T3_int", 32'(interrupt), 32'd0);
        chk("t1_T3_insvc", 32'(in_service), 32'd1);
        chk("t1_T3_pend", 32'(pending), 32'd0);
        chk("t1_T3_count", 32'(irq_count), 32'd1);
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;
        chk("t1_ret_insvc", 32'(in_service), 32'd0);
        chk("t1_ret_spur", 32'(spurious_ret), 32'd0);

        // 2: simultaneous sources 3 and 1, lowest index first
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b1010;
        cycle(); irq_src = '0; #1;
        chk("t2_pend", 32'(pending), 32'b1010);
        cycle(); #1;
        chk("t2_int1", 32'(interrupt), 32'd1);
        chk("t2_cause1", 32'(cause_id), 32'd1);
        cycle(); #1;
        chk("t2_pend_after1", 32'(pending), 32'b1000);
        chk("t2_insvc1", 32'(in_service), 32'd1);
        rsi = 1'b1;                              // return accepted at R
        cycle(); rsi = 1'b0; #1;                 // R+1
        chk("t2_R1_int", 32'(interrupt), 32'd0);
        chk("t2_R1_insvc", 32'(in_service), 32'd0);
        cycle(); #1;                             // R+2
        chk("t2_R2_int", 32'(interrupt), 32'd1);
        chk("t2_cause2", 32'(cause_id), 32'd3);
        cycle(); #1;
        chk("t2_count", 32'(irq_count), 32'd2);
        chk("t2_pend_final", 32'(pending), 32'd0);
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;

        // 3: stall then flush hold the strobe in ARM
        irq_src = 4'b0010;
        stall   = 1'b1;
        cycle(); irq_src = '0; #1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(); #1;
            seen += int'(interrupt);
        end
        chk("t3_stall_no_int", 32'(seen), 32'd0);
        stall = 1'b0;
        flush = 1'b1;
        #1;
        chk("t3_flush_int", 32'(interrupt), 32'd0);
        cycle(); flush = 1'b0; #1;
        chk("t3_fire_int", 32'(interrupt), 32'd1);
        chk("t3_fire_cause", 32'(cause_id), 32'd1);
        cycle(); #1;
        chk("t3_insvc", 32'(in_service), 32'd1);
        chk("t3_count", 32'(irq_count), 32'd3);
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;

        // 4: masked source stays pending until enabled
        do_reset();
        irq_src = 4'b0001;
        cycle(); irq_src = '0; #1;
        chk("t4_pend", 32'(pending), 32'b0001);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(); #1;
            seen += int'(interrupt);
        end
        chk("t4_no_strobe", 32'(seen), 32'd0);
        chk("t4_pend_held", 32'(pending), 32'b0001);
        set_mask(4'b0001); #1;
        chk("t4_W1_int", 32'(interrupt), 32'd0);
        cycle(); #1;
        chk("t4_W2_int", 32'(interrupt), 32'd1);
        chk("t4_cause", 32'(cause_id), 32'd0);
        cycle();
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;

        // 5: spurious return, re-request during service, reset mid-service
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;
        chk("t5_spur", 32'(spurious_ret), 32'd1);
        cycle(); #1;
        chk("t5_idle_int", 32'(interrupt), 32'd0);
        chk("t5_idle_insvc", 32'(in_service), 32'd0);
        irq_src = 4'b0001;                       // T
        cycle(); irq_src = '0;                   // T+1
        cycle(); #1;                             // T+2
        chk("t5_int1", 32'(interrupt), 32'd1);
        cycle(); irq_src = 4'b0001; #1;          // T+3, SERVICE
        chk("t5_insvc", 32'(in_service), 32'd1);
        cycle(); irq_src = '0; #1;               // T+4
        chk("t5_repend", 32'(pending), 32'b0001);
        chk("t5_insvc_held", 32'(in_service), 32'd1);
        rti = 1'b1;
        cycle(); rti = 1'b0; #1;                 // T+5
        chk("t5_ret_insvc", 32'(in_service), 32'd0);
        cycle(); #1;                             // T+6
        chk("t5_int2", 32'(interrupt), 32'd1);
        chk("t5_cause2", 32'(cause_id), 32'd0);
        cycle(); #1;                             // T+7
        chk("t5_insvc2", 32'(in_service), 32'd1);
        chk("t5_spur_sticky", 32'(spurious_ret), 32'd1);
        rst_n = 1'b0;
        cycle(); #1;
        chk_reset("t5_rst");
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
